stack_unit: RTL and testbench
=============================

Name: stack_unit

Overview:
- Parametrised hardware stack: a bounded descending stack pointer plus on-block storage, with full/empty status, sticky fault flags and a registered pop data path.
- Sits beside the register file and serves PUSH/POP/CALL/RET and load-SP micro-ops from the control unit.
- Compared with the plain stack pointer, it adds bound checking, storage, occupancy count and error reporting. It never wraps silently.

Parameters:
- DATA_W, 8, width of a stack entry.
- ADDR_W, 8, width of stack pointer and load value.
- SP_TOP, 8'hFF, highest stack address; SP value when the stack is empty.
- SP_BOTTOM, 8'hB0, lowest usable address. Default depth is SP_TOP-SP_BOTTOM+1 = 80. Legal range is SP_TOP >= SP_BOTTOM >= 1.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- op_valid  input  1  command strobe; an operation is accepted on any edge where op_valid=1.
- op  input  2  00 NOP, 01 PUSH, 10 POP, 11 LOAD.
- push_data  input  DATA_W  entry written on PUSH.
- load_sp  input  ADDR_W  new SP value for LOAD (driven from r0).
- err_clr  input  1  clears all sticky error flags.
- sp  output  ADDR_W  current stack pointer; points to the next free slot.
- pop_data  output  DATA_W  registered data of the last successful POP.
- pop_valid  output  1  one-cycle pulse, one cycle after a successful POP.
- full  output  1  high when sp == SP_BOTTOM-1.
- empty  output  1  high when sp == SP_TOP.
- level  output  ADDR_W  number of entries held, equal to SP_TOP - sp.
- err_ovf  output  1  sticky: a PUSH was attempted while full.
- err_unf  output  1  sticky: a POP was attempted while empty.
- err_load  output  1  sticky: a LOAD was attempted with an out-of-range value.

Behaviour:
- Reset (asynchronous, any time, including mid-operation):
  - sp = SP_TOP, empty = 1, full = 0, level = 0.
  - pop_valid = 0, pop_data = 0, all error flags = 0.
  - Storage contents are not reset and are undefined after power-up.
- Storage: an array of SP_TOP-SP_BOTTOM+1 entries, indexed by (address - SP_BOTTOM).
  - Synchronous write.
  - Registered read; the read address is computed combinationally from sp+1.
- Empty-descending convention:
  - PUSH: mem[sp] <= push_data, then sp <= sp-1.
  - POP: pop_data <= mem[sp+1], then sp <= sp+1.
- PUSH when full:
  - No write; sp unchanged; err_ovf <= 1.
- POP when empty:
  - sp unchanged; pop_data holds its previous value; pop_valid stays 0; err_unf <= 1.
- POP latency:
  - The POP is accepted at edge N; pop_data is updated and pop_valid = 1 for the cycle following edge N.
  - pop_valid clears at edge N+1 unless another successful POP is accepted at that edge.
  - Back-to-back POPs on consecutive cycles are supported at one per cycle.
- LOAD:
  - Accepted when SP_BOTTOM-1 <= load_sp <= SP_TOP; sp <= load_sp. full, empty and level follow the new sp next cycle.
  - Rejected when out of range: sp unchanged; err_load <= 1.
  - Storage is untouched in both cases.
- NOP, or op_valid = 0: no state change except that pop_valid clears.
- full, empty and level are combinational from the registered sp, so they are valid in the same cycle as sp.
- Error flags:
  - Each flag is sticky until err_clr = 1.
  - If err_clr and a new fault occur on the same edge, the set wins (the flag reads 1 after the edge).
  - Error flags never block later operations.
- Arithmetic: sp is updated modulo 2^ADDR_W internally. The bound checks above guarantee it never leaves [SP_BOTTOM-1, SP_TOP], so no wrap-around is ever visible.
- Throughput: one operation per cycle. There is no back-pressure and no ready signal.

Test Plan:
- Reset, then idle 3 cycles -> sp = 8'hFF, empty = 1, full = 0, level = 0, all error flags 0, pop_valid = 0.
- PUSH 8'h11, 8'h22, 8'h33, then 3 POPs back-to-back -> sp steps FF→FE→FD→FC then back to FF; pop_data reads 33, 22, 11 on consecutive cycles with pop_valid high for each of those 3 cycles; empty = 1 at the end.
- 80 PUSHes of 0..79 -> sp = 8'hAF, full = 1, level = 80. An 81st PUSH of 8'hEE -> sp stays AF, err_ovf = 1. A following POP returns 79 (8'h4F), showing 8'hEE was never written.
- POP on empty stack -> sp stays FF, pop_valid = 0, err_unf = 1. Then err_clr asserted alone -> err_unf = 0. err_clr together with another empty POP -> err_unf stays 1.
- LOAD 8'hC0 -> sp = C0, level = 63. LOAD 8'hAE -> sp stays C0, err_load = 1. LOAD 8'hAF -> sp = AF, full = 1.
- Assert rst_n low asynchronously between edges, immediately after a POP has been accepted -> pop_valid drops without waiting for a clock edge; sp = FF and all flags clear while rst_n is low.

Source files
------------

// File: rtl/stack_unit.sv
// -----------------------------------------------------------------------------
// stack_unit
//
// Bounded, descending hardware stack with on-block storage. It serves the
// PUSH / POP / LOAD-SP micro-ops issued by the control unit. It keeps an
// occupancy count and full/empty status. Bound violations are reported through
// sticky error flags, and the stack pointer is never allowed to wrap.
//
// The stack pointer always names the next free slot (empty-descending):
//   PUSH : mem[sp] <= push_data, sp <= sp - 1
//   POP  : pop_data <= mem[sp + 1], sp <= sp + 1   (one-cycle pop_valid pulse)
//   LOAD : sp <= load_sp when SP_BOTTOM-1 <= load_sp <= SP_TOP
//
// Ports
//   clk        system clock, rising-edge active
//   rst_n      asynchronous active-low reset
//   op_valid   command strobe; an op is accepted on every edge it is high
//   op         00 NOP, 01 PUSH, 10 POP, 11 LOAD
//   push_data  entry written by PUSH
//   load_sp    new stack pointer for LOAD
//   err_clr    clears the sticky error flags (a new fault on the same edge wins)
//   sp         current stack pointer
//   pop_data   registered data of the last successful POP
//   pop_valid  pulses for one cycle after each successful POP
//   full       sp == SP_BOTTOM - 1
//   empty      sp == SP_TOP
//   level      number of entries held (SP_TOP - sp)
//   err_ovf    sticky: PUSH attempted while full
//   err_unf    sticky: POP attempted while empty
//   err_load   sticky: LOAD attempted with an out-of-range value
// -----------------------------------------------------------------------------
module stack_unit #(
    parameter int unsigned       DATA_W    = 8,
    parameter int unsigned       ADDR_W    = 8,
    parameter logic [ADDR_W-1:0] SP_TOP    = 8'hFF,
    parameter logic [ADDR_W-1:0] SP_BOTTOM = 8'hB0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              op_valid,
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] push_data,
    input  logic [ADDR_W-1:0] load_sp,
    input  logic              err_clr,
    output logic [ADDR_W-1:0] sp,
    output logic [DATA_W-1:0] pop_data,
    output logic              pop_valid,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W-1:0] level,
    output logic              err_ovf,
    output logic              err_unf,
    output logic              err_load
);

    typedef enum logic [1:0] {
        OP_NOP  = 2'b00,
        OP_PUSH = 2'b01,
        OP_POP  = 2'b10,
        OP_LOAD = 2'b11
    } op_e;

    localparam int unsigned DEPTH = 32'(SP_TOP) - 32'(SP_BOTTOM) + 1;
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // sp value when every slot is occupied
    localparam logic [ADDR_W-1:0] SP_FULL   = SP_BOTTOM - ADDR_W'(1);
    // number of legal LOAD values above SP_FULL
    localparam logic [ADDR_W-1:0] LOAD_SPAN = SP_TOP - SP_FULL;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] sp_q;

    op_e              op_cmd;
    logic             is_push;
    logic             is_pop;
    logic             is_load;
    logic             load_in_range;
    logic             push_ok;
    logic             pop_ok;
    logic             load_ok;
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_idx;

    assign op_cmd  = op_e'(op);
    assign is_push = op_valid && (op_cmd == OP_PUSH);
    assign is_pop  = op_valid && (op_cmd == OP_POP);
    assign is_load = op_valid && (op_cmd == OP_LOAD);

    // Status is decoded straight from the registered pointer so it is valid
    // in the same cycle as sp.
    assign sp    = sp_q;
    assign full  = (sp_q == SP_FULL);
    assign empty = (sp_q == SP_TOP);
    assign level = SP_TOP - sp_q;

    // Offsetting by SP_FULL turns the two-sided range check into a single
    // unsigned compare: values below SP_FULL wrap to large offsets.
    assign load_in_range = (ADDR_W'(load_sp - SP_FULL) <= LOAD_SPAN);

    assign push_ok = is_push && !full;
    assign pop_ok  = is_pop && !empty;
    assign load_ok = is_load && load_in_range;

    // Slot addresses relative to the bottom of the storage array. Both indices
    // are only used when the corresponding op is legal, so they always hit a
    // real entry when they matter.
    assign wr_idx = IDX_W'(sp_q - SP_BOTTOM);
    assign rd_idx = IDX_W'(sp_q - SP_FULL);

    // NOTE: storage carries no reset. Its contents are undefined after
    // power-up, and leaving it out of the reset tree lets it map onto RAM.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_idx] <= push_data;
        end
    end

    // NOTE: all sequential state uses non-blocking assignments, so every
    // right-hand side sees the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp_q      <= SP_TOP;
            pop_valid <= 1'b0;
            pop_data  <= '0;
            err_ovf   <= 1'b0;
            err_unf   <= 1'b0;
            err_load  <= 1'b0;
        end else begin
            pop_valid <= pop_ok;
            if (pop_ok) begin
                pop_data <= mem[rd_idx];
            end

            if (push_ok) begin
                sp_q <= sp_q - ADDR_W'(1);
            end else if (pop_ok) begin
                sp_q <= sp_q + ADDR_W'(1);
            end else if (load_ok) begin
                sp_q <= load_sp;
            end

            // A new fault takes priority over err_clr on the same edge.
            err_ovf  <= (is_push && full)           || (err_ovf  && !err_clr);
            err_unf  <= (is_pop && empty)           || (err_unf  && !err_clr);
            err_load <= (is_load && !load_in_range) || (err_load && !err_clr);
        end
    end

endmodule

// File: tb/tb_stack_unit.sv
// -----------------------------------------------------------------------------
// tb_stack_unit
//
// Self-checking bench for stack_unit. Directed scenarios check the documented
// behaviour against constant expectations. A randomized run checks every cycle
// against an address-indexed behavioural model of the stack.
// -----------------------------------------------------------------------------
module tb_stack_unit;

    localparam int TOP = 8'hFF;
    localparam int BOT = 8'hB0;

    logic       clk;
    logic       rst_n;
    logic       op_valid;
    logic [1:0] op;
    logic [7:0] push_data;
    logic [7:0] load_sp;
    logic       err_clr;
    logic [7:0] sp;
    logic [7:0] pop_data;
    logic       pop_valid;
    logic       full;
    logic       empty;
    logic [7:0] level;
    logic       err_ovf;
    logic       err_unf;
    logic       err_load;

    int n_checks = 0;
    int n_fail   = 0;

    // behavioural model state
    int         m_sp;
    logic [7:0] m_mem [int];
    logic [7:0] e_pd;
    bit         e_pd_known;
    bit         e_pv;
    bit         e_ovf;
    bit         e_unf;
    bit         e_load;

    stack_unit #(
        .DATA_W    (8),
        .ADDR_W    (8),
        .SP_TOP    (8'hFF),
        .SP_BOTTOM (8'hB0)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .op_valid  (op_valid),
        .op        (op),
        .push_data (push_data),
        .load_sp   (load_sp),
        .err_clr   (err_clr),
        .sp        (sp),
        .pop_data  (pop_data),
        .pop_valid (pop_valid),
        .full      (full),
        .empty     (empty),
        .level     (level),
        .err_ovf   (err_ovf),
        .err_unf   (err_unf),
        .err_load  (err_load)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic model_reset();
        m_sp       = TOP;
        m_mem.delete();
        e_pd       = 8'h00;
        e_pd_known = 1'b1;
        e_pv       = 1'b0;
        e_ovf      = 1'b0;
        e_unf      = 1'b0;
        e_load     = 1'b0;
    endtask

    // Stack rules: the next free slot is m_sp, entries live above it.
    task automatic model_step(bit v, logic [1:0] o, logic [7:0] pd, logic [7:0] ld, bit clr);
        bit s_ovf  = 1'b0;
        bit s_unf  = 1'b0;
        bit s_load = 1'b0;
        e_pv = 1'b0;
        if (v) begin
            case (o)
                2'b01: begin
                    if (m_sp == BOT - 1) s_ovf = 1'b1;
                    else begin
                        m_mem[m_sp] = pd;
                        m_sp = m_sp - 1;
                    end
                end
                2'b10: begin
                    if (m_sp == TOP) s_unf = 1'b1;
                    else begin
                        m_sp = m_sp + 1;
                        e_pv = 1'b1;
                        if (m_mem.exists(m_sp)) begin
                            e_pd = m_mem[m_sp];
                            e_pd_known = 1'b1;
                        end else begin
                            e_pd_known = 1'b0;
                        end
                    end
                end
                2'b11: begin
                    if (int'(ld) >= BOT - 1 && int'(ld) <= TOP) m_sp = int'(ld);
                    else s_load = 1'b1;
                end
                default: ;
            endcase
        end
        e_ovf  = s_ovf  || (e_ovf  && !clr);
        e_unf  = s_unf  || (e_unf  && !clr);
        e_load = s_load || (e_load && !clr);
    endtask

    // Apply one operation around one rising edge; returns 1 time unit after it.
    task automatic drive(bit v, logic [1:0] o, logic [7:0] pd, logic [7:0] ld, bit clr);
        @(negedge clk);
        op_valid  = v;
        op        = o;
        push_data = pd;
        load_sp   = ld;
        err_clr   = clr;
        @(posedge clk);
        model_step(v, o, pd, ld, clr);
        #1;
        op_valid = 1'b0;
        err_clr  = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        op_valid = 1'b0; op = 2'b00; push_data = 8'h00; load_sp = 8'h00; err_clr = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        repeat (3) drive(1'b0, 2'b00, 8'h00, 8'h00, 1'b0);
        n_checks++; if (sp !== 8'hFF) begin n_fail++; $display("FAIL reset_sp: got %h expected ff", sp); end
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b expected 1", empty); end
        n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b expected 0", full); end
        n_checks++; if (level !== 8'd0) begin n_fail++; $display("FAIL reset_level: got %0d expected 0", level); end
        n_checks++; if ({err_ovf, err_unf, err_load} !== 3'b000) begin n_fail++; $display("FAIL reset_errs: got %b expected 000", {err_ovf, err_unf, err_load}); end
        n_checks++; if (pop_valid !== 1'b0) begin n_fail++; $display("FAIL reset_pop_valid: got %b expected 0", pop_valid); end
        n_checks++; if (pop_data !== 8'h00) begin n_fail++; $display("FAIL reset_pop_data: got %h expected 00", pop_data); end
    endtask

    task automatic test_push_pop();
        logic [7:0] vals [3];
        logic [7:0] exp_sp;
        vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 2'b01, vals[i], 8'h00, 1'b0);
            exp_sp = 8'hFE - 8'(i);
            n_checks++; if (sp !== exp_sp) begin n_fail++; $display("FAIL push_sp[%0d]: got %h expected %h", i, sp, exp_sp); end
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 2'b10, 8'h00, 8'h00, 1'b0);
            exp_sp = 8'hFD + 8'(i);
            n_checks++; if (sp !== exp_sp) begin n_fail++; $display("FAIL pop_sp[%0d]: got %h expected %h", i, sp, exp_sp); end
            n_checks++; if (pop_valid !== 1'b1) begin n_fail++; $display("FAIL pop_valid[%0d]: got %b expected 1", i, pop_valid); end
            n_checks++; if (pop_data !== vals[2-i]) begin n_fail++; $display("FAIL pop_data[%0d]: got %h expected %h", i, pop_data, vals[2-i]); end
        end
        drive(1'b0, 2'b00, 8'h00, 8'h00, 1'b0);
        n_checks++; if (pop_valid !== 1'b0) begin n_fail++; $display("FAIL pop_valid_clear: got %b expected 0", pop_valid); end
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL pop_empty_end: got %b expected 1", empty); end
    endtask

    task automatic test_full_overflow();
        for (int i = 0; i < 80; i++) drive(1'b1, 2'b01, 8'(i), 8'h00, 1'b0);
        n_checks++; if (sp !== 8'hAF) begin n_fail++; $display("FAIL full_sp: got %h expected af", sp); end
        n_checks++; if (full !== 1'b1) begin n_fail++; $display("FAIL full_flag: got %b expected 1", full); end
        n_checks++; if (level !== 8'd80) begin n_fail++; $display("FAIL full_level: got %0d expected 80", level); end
        n_checks++; if (err_ovf !== 1'b0) begin n_fail++; $display("FAIL full_no_ovf: got %b expected 0", err_ovf); end
        drive(1'b1, 2'b01, 8'hEE, 8'h00, 1'b0);
        n_checks++; if (sp !== 8'hAF) begin n_fail++; $display("FAIL ovf_sp: got %h expected af", sp); end
        n_checks++; if (err_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b expected 1", err_ovf); end
        drive(1'b1, 2'b10, 8'h00, 8'h00, 1'b0);
        n_checks++; if (pop_data !== 8'h4F) begin n_fail++; $display("FAIL ovf_pop_data: got %h expected 4f", pop_data); end
        n_checks++; if (sp !== 8'hB0) begin n_fail++; $display("FAIL ovf_pop_sp: got %h expected b0", sp); end
        n_checks++; if (err_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b expected 1", err_ovf); end
        drive(1'b1, 2'b11, 8'h00, 8'hFF, 1'b1);
        n_checks++; if (sp !== 8'hFF || err_ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_cleanup: got sp=%h ovf=%b expected sp=ff ovf=0", sp, err_ovf); end
    endtask

    task automatic test_underflow_clear();
        drive(1'b1, 2'b10, 8'h00, 8'h00, 1'b0);
        n_checks++; if (sp !== 8'hFF) begin n_fail++; $display("FAIL unf_sp: got %h expected ff", sp); end
        n_checks++; if (pop_valid !== 1'b0) begin n_fail++; $display("FAIL unf_pop_valid: got %b expected 0", pop_valid); end
        n_checks++; if (err_unf !== 1'b1) begin n_fail++; $display("FAIL unf_flag: got %b expected 1", err_unf); end
        n_checks++; if (pop_data !== 8'h4F) begin n_fail++; $display("FAIL unf_pop_data_hold: got %h expected 4f", pop_data); end
        drive(1'b0, 2'b00, 8'h00, 8'h00, 1'b1);
        n_checks++; if (err_unf !== 1'b0) begin n_fail++; $display("FAIL unf_clear: got %b expected 0", err_unf); end
        drive(1'b1, 2'b10, 8'h00, 8'h00, 1'b1);
        n_checks++; if (err_unf !== 1'b1) begin n_fail++; $display("FAIL unf_set_wins: got %b expected 1", err_unf); end
        drive(1'b0, 2'b00, 8'h00, 8'h00, 1'b1);
    endtask

    task automatic test_load();
        drive(1'b1, 2'b11, 8'h00, 8'hC0, 1'b0);
        n_checks++; if (sp !== 8'hC0) begin n_fail++; $display("FAIL load_c0_sp: got %h expected c0", sp); end
        n_checks++; if (level !== 8'd63) begin n_fail++; $display("FAIL load_c0_level: got %0d expected 63", level); end
        drive(1'b1, 2'b11, 8'h00, 8'hAE, 1'b0);
        n_checks++; if (sp !== 8'hC0) begin n_fail++; $display("FAIL load_ae_sp: got %h expected c0", sp); end
        n_checks++; if (err_load !== 1'b1) begin n_fail++; $display("FAIL load_ae_err: got %b expected 1", err_load); end
        drive(1'b1, 2'b11, 8'h00, 8'hAF, 1'b0);
        n_checks++; if (sp !== 8'hAF) begin n_fail++; $display("FAIL load_af_sp: got %h expected af", sp); end
        n_checks++; if (full !== 1'b1) begin n_fail++; $display("FAIL load_af_full: got %b expected 1", full); end
        drive(1'b1, 2'b11, 8'h00, 8'hFF, 1'b1);
        n_checks++; if (sp !== 8'hFF || err_load !== 1'b0) begin n_fail++; $display("FAIL load_cleanup: got sp=%h err_load=%b expected sp=ff err_load=0", sp, err_load); end
    endtask

    task automatic test_random();
        int         r;
        bit         v;
        logic [1:0] o;
        logic [7:0] pd;
        logic [7:0] ld;
        bit         clr;
        logic [7:0] exp_sp;
        logic [7:0] exp_lvl;
        for (int c = 0; c < 600; c++) begin
            r  = $urandom_range(0, 99);
            v  = (r < 90);
            o  = (r < 45) ? 2'b01 : (r < 78) ? 2'b10 : (r < 86) ? 2'b11 : 2'b00;
            pd = 8'($urandom);
            ld = ($urandom_range(0, 3) != 0) ? 8'($urandom_range(TOP, BOT - 1)) : 8'($urandom);
            clr = ($urandom_range(0, 15) == 0);
            drive(v, o, pd, ld, clr);
            exp_sp  = 8'(m_sp);
            exp_lvl = 8'(TOP - m_sp);
            n_checks++; if (sp !== exp_sp) begin n_fail++; $display("FAIL rand_sp@%0d: got %h expected %h", c, sp, exp_sp); end
            n_checks++; if (level !== exp_lvl) begin n_fail++; $display("FAIL rand_level@%0d: got %0d expected %0d", c, level, exp_lvl); end
            n_checks++; if (full !== (m_sp == BOT - 1) || empty !== (m_sp == TOP)) begin n_fail++; $display("FAIL rand_status@%0d: got full=%b empty=%b expected full=%b empty=%b", c, full, empty, m_sp == BOT - 1, m_sp == TOP); end
            n_checks++; if (pop_valid !== e_pv) begin n_fail++; $display("FAIL rand_pop_valid@%0d: got %b expected %b", c, pop_valid, e_pv); end
            if (e_pd_known) begin
                n_checks++; if (pop_data !== e_pd) begin n_fail++; $display("FAIL rand_pop_data@%0d: got %h expected %h", c, pop_data, e_pd); end
            end
            n_checks++; if ({err_ovf, err_unf, err_load} !== {e_ovf, e_unf, e_load}) begin n_fail++; $display("FAIL rand_errs@%0d: got %b expected %b", c, {err_ovf, err_unf, err_load}, {e_ovf, e_unf, e_load}); end
        end
    endtask

    task automatic test_async_reset();
        drive(1'b1, 2'b11, 8'h00, 8'hFF, 1'b1);
        drive(1'b1, 2'b10, 8'h00, 8'h00, 1'b0);
        drive(1'b1, 2'b01, 8'h5A, 8'h00, 1'b0);
        drive(1'b1, 2'b10, 8'h00, 8'h00, 1'b0);
        n_checks++; if (pop_valid !== 1'b1 || pop_data !== 8'h5A) begin n_fail++; $display("FAIL arst_pre_pop: got valid=%b data=%h expected valid=1 data=5a", pop_valid, pop_data); end
        n_checks++; if (err_unf !== 1'b1) begin n_fail++; $display("FAIL arst_pre_unf: got %b expected 1", err_unf); end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if (pop_valid !== 1'b0) begin n_fail++; $display("FAIL arst_pop_valid: got %b expected 0", pop_valid); end
        n_checks++; if (sp !== 8'hFF || empty !== 1'b1 || level !== 8'd0) begin n_fail++; $display("FAIL arst_sp: got sp=%h empty=%b level=%0d expected sp=ff empty=1 level=0", sp, empty, level); end
        n_checks++; if ({err_ovf, err_unf, err_load} !== 3'b000) begin n_fail++; $display("FAIL arst_errs: got %b expected 000", {err_ovf, err_unf, err_load}); end
        n_checks++; if (pop_data !== 8'h00) begin n_fail++; $display("FAIL arst_pop_data: got %h expected 00", pop_data); end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        drive(1'b0, 2'b00, 8'h00, 8'h00, 1'b0);
        n_checks++; if (sp !== 8'hFF || pop_valid !== 1'b0) begin n_fail++; $display("FAIL arst_release: got sp=%h valid=%b expected sp=ff valid=0", sp, pop_valid); end
    endtask

    initial begin
        test_reset();
        test_push_pop();
        test_full_overflow();
        test_underflow_clear();
        test_load();
        test_random();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
